// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin stream mergers.
// beat_t is the default-width view of one output beat (id, last flag, payload).
package rr_arb_pkg;

   typedef enum logic {ARB, LOCK} arb_state_e;

   function automatic int idw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_N_IN       = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_IDW        = idw(DEF_N_IN);

   typedef struct packed {
      logic [DEF_IDW-1:0]        id;
      logic                      last;
      logic [DEF_DATA_WIDTH-1:0] data;
   } beat_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr wins, else the lowest below it.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int N  = DEF_N_IN,
   parameter int IW = idw(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx
);

   logic          hi_valid;
   logic          lo_valid;
   logic [IW-1:0] hi_idx;
   logic [IW-1:0] lo_idx;

   // Descending scan so the last hit in each half is its lowest index.
   always_comb begin
      hi_valid = 1'b0;
      lo_valid = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (IW'(i) >= ptr) begin
               hi_valid = 1'b1;
               hi_idx   = IW'(i);
            end else begin
               lo_valid = 1'b1;
               lo_idx   = IW'(i);
            end
         end
      end
      gnt_valid = hi_valid || lo_valid;
      gnt_idx   = hi_valid ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/transkidbuf.sv
// Two-entry skid buffer: registered output, one overflow slot that catches the beat in flight during a stall.
// empty_next tells the owner whether both slots will be empty after the coming clock edge.
module transkidbuf #(
   parameter int WIDTH      = 8,
   parameter bit PASS_STALL = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             empty_next
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             load;
   logic             push;

   assign in_ready   = !skid_valid || (PASS_STALL && out_ready);
   assign load       = !out_valid || out_ready;
   assign push       = in_valid && in_ready;
   assign empty_next = !(!load || skid_valid || push)
                       && !(load ? (skid_valid && push) : (skid_valid || push));

   // The skid slot always drains into the output register before new data does, preserving order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (load) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= push;
            if (push) skid_data <= in_data;
         end else begin
            out_valid <= push;
            if (push) out_data <= in_data;
         end
      end else if (push) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin merger of N_IN packetised valid/ready streams into one registered output stream.
// A grant stays locked on its input until the packet's last beat is accepted.
module rr_stream_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N_IN       = DEF_N_IN,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IDW        = idw(N_IN)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       arb_en,
   input  logic [N_IN-1:0]            in_valid,
   input  logic [N_IN-1:0]            in_last,
   input  logic [N_IN*DATA_WIDTH-1:0] in_data,
   output logic [N_IN-1:0]            in_ready,
   output logic                       out_valid,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_last,
   output logic [IDW-1:0]             out_id,
   input  logic                       out_ready,
   output logic                       quiesced
);

   typedef struct packed {
      logic [IDW-1:0]        id;
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } beat_w_t;

   arb_state_e            state, state_next;
   logic [IDW-1:0]        ptr, ptr_next;
   logic [IDW-1:0]        lock_idx, lock_idx_next;
   logic [IDW-1:0]        g;
   logic [IDW-1:0]        pick_idx;
   logic                  pick_valid;
   logic                  granted;
   logic                  accept;
   logic                  skid_ready;
   logic                  skid_empty_next;
   logic [DATA_WIDTH-1:0] in_words [N_IN];
   beat_w_t               beat_in;
   beat_w_t               beat_out;

   rr_pick #(.N(N_IN), .IW(IDW)) u_pick (
      .req       (in_valid & {N_IN{arb_en}}),
      .ptr       (ptr),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         in_words[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Grant selection, handshake and next-state; ready is suppressed while reset is asserted.
   always_comb begin
      state_next    = state;
      ptr_next      = ptr;
      lock_idx_next = lock_idx;
      granted       = 1'b0;
      g             = lock_idx;
      case (state)
         ARB: begin
            granted = pick_valid;
            g       = pick_idx;
         end
         LOCK: begin
            granted = 1'b1;
            g       = lock_idx;
         end
         default: ;
      endcase
      granted = granted && rstn;
      accept  = granted && in_valid[g] && skid_ready;
      if (accept) begin
         if (in_last[g]) begin
            state_next = ARB;
            ptr_next   = (g == IDW'(N_IN - 1)) ? '0 : g + 1'b1;
         end else begin
            state_next    = LOCK;
            lock_idx_next = g;
         end
      end
      for (int i = 0; i < N_IN; i++) begin
         in_ready[i] = granted && skid_ready && (g == IDW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= ARB;
         ptr      <= '0;
         lock_idx <= '0;
         quiesced <= 1'b0;
      end else begin
         state    <= state_next;
         ptr      <= ptr_next;
         lock_idx <= lock_idx_next;
         quiesced <= !arb_en && (state_next == ARB) && skid_empty_next;
      end
   end

   assign beat_in.id   = g;
   assign beat_in.last = in_last[g];
   assign beat_in.data = in_words[g];

   transkidbuf #(.WIDTH(DATA_WIDTH + 1 + IDW), .PASS_STALL(1'b0)) u_skid (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (accept),
      .in_data    (beat_in),
      .in_ready   (skid_ready),
      .out_valid  (out_valid),
      .out_data   (beat_out),
      .out_ready  (out_ready),
      .empty_next (skid_empty_next)
   );

   assign out_id   = beat_out.id;
   assign out_last = beat_out.last;
   assign out_data = beat_out.data;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: reference arbitration model with a scoreboard queue,
// a vector table for grant order, and directed sequences for lock, stall, wrap, quiesce and reset.
module tb_rr_stream_arbiter;
   import rr_arb_pkg::*;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int IDW = 2;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            arb_en = 1'b1;
   logic            out_ready = 1'b1;
   logic [N-1:0]    in_valid = '1;
   logic [N-1:0]    in_last = '1;
   logic [N*DW-1:0] in_data = '0;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [IDW-1:0]  out_id;
   logic            quiesced;

   always #5 clk = ~clk;

   rr_stream_arbiter #(.N_IN(N), .DATA_WIDTH(DW), .IDW(IDW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .arb_en    (arb_en),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_id    (out_id),
      .out_ready (out_ready),
      .quiesced  (quiesced)
   );

   typedef struct {
      logic         en;
      logic [N-1:0] valid;
      logic [N-1:0] exp_ready;
   } vec_t;

   int            n_checks = 0;
   int            n_fail = 0;
   int            cycle = 0;
   int            m_ptr = 0;
   int            m_lock = 0;
   int            m_occ = 0;
   bit            m_locked = 1'b0;
   bit            m_q = 1'b0;
   beat_t         sb[$];
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   logic [IDW-1:0] prev_id;
   int            log_id[$];
   int            log_cyc[$];
   logic          log_last[$];
   logic [DW-1:0] log_data[$];
   logic [N-1:0]  acc_seen = '0;
   int            pkt_q[N][$];
   int            beat_no[N];
   int            seq_no[N];
   bit            use_src = 1'b0;
   vec_t          vecs[10];
   int            exp_q[$];

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Reference model: predicts grants from the spec's search order and tracks output-stage occupancy.
   task automatic monitor();
      int     g;
      bit     gv;
      bit     m_acc;
      bit     pop;
      logic [N-1:0] rdy_exp;
      beat_t  got_b;
      beat_t  exp_b;
      cycle++;
      if (!rstn) begin
         m_ptr = 0; m_lock = 0; m_occ = 0; m_locked = 1'b0; m_q = 1'b0;
         sb.delete();
         prev_stall = 1'b0;
         acc_seen = '0;
         return;
      end
      check_output("out_valid", 64'(out_valid), 64'(m_occ > 0));
      check_output("quiesced", 64'(quiesced), 64'(m_q));
      if (prev_stall)
         check_output("stall_hold", 64'({out_id, out_last, out_data}), 64'({prev_id, prev_last, prev_data}));
      pop = (m_occ > 0) && out_ready;
      if (out_valid && out_ready) begin
         got_b = {out_id, out_last, out_data};
         log_id.push_back(int'(out_id));
         log_cyc.push_back(cycle);
         log_last.push_back(out_last);
         log_data.push_back(out_data);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL sb_underflow: got beat %0h, expected no beat (cycle %0d)", got_b, cycle);
         end else begin
            exp_b = sb.pop_front();
            check_output("out_beat", 64'(got_b), 64'(exp_b));
         end
      end
      gv = 1'b0;
      g  = 0;
      if (m_locked) begin
         gv = 1'b1;
         g  = m_lock;
      end else if (arb_en) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!gv && in_valid[idx]) begin
               gv = 1'b1;
               g  = idx;
            end
         end
      end
      rdy_exp = '0;
      if (gv && m_occ < 2) rdy_exp[g] = 1'b1;
      check_output("in_ready", 64'(in_ready), 64'(rdy_exp));
      acc_seen = in_valid & in_ready;
      m_acc = gv && (m_occ < 2) && in_valid[g];
      if (m_acc) begin
         sb.push_back({2'(g), in_last[g], in_data[g*DW +: DW]});
         if (in_last[g]) begin
            m_locked = 1'b0;
            m_ptr    = (g + 1) % N;
         end else begin
            m_locked = 1'b1;
            m_lock   = g;
         end
      end
      m_occ = m_occ + int'(m_acc) - int'(pop);
      m_q   = !arb_en && !m_locked && (m_occ == 0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_id    = out_id;
   endtask

   task automatic drive_sources();
      for (int i = 0; i < N; i++) begin
         if (pkt_q[i].size() > 0) begin
            in_valid[i] = 1'b1;
            in_last[i]  = (beat_no[i] == pkt_q[i][0] - 1);
            in_data[i*DW +: DW] = {8'(i), 24'(seq_no[i])};
         end else begin
            in_valid[i] = 1'b0;
            in_last[i]  = 1'b0;
         end
      end
   endtask

   task automatic advance_sources();
      for (int i = 0; i < N; i++) begin
         if (acc_seen[i] && pkt_q[i].size() > 0) begin
            seq_no[i]++;
            if (beat_no[i] == pkt_q[i][0] - 1) begin
               void'(pkt_q[i].pop_front());
               beat_no[i] = 0;
            end else begin
               beat_no[i]++;
            end
         end
      end
   endtask

   task automatic apply_stimulus();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (use_src) begin
         advance_sources();
         drive_sources();
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0; in_valid = '1; in_last = '1; arb_en = 1'b1; out_ready = 1'b1; use_src = 1'b0;
      for (int i = 0; i < N; i++) begin
         pkt_q[i].delete();
         beat_no[i] = 0;
         seq_no[i]  = 0;
      end
      @(negedge clk);
      monitor();
      check_output("rst_in_ready_comb", 64'(in_ready), 64'(0));
      repeat (2) begin
         @(negedge clk);
         monitor();
         check_output("rst_in_ready", 64'(in_ready), 64'(0));
         check_output("rst_out_valid", 64'(out_valid), 64'(0));
         check_output("rst_out_id", 64'(out_id), 64'(0));
         check_output("rst_quiesced", 64'(quiesced), 64'(0));
      end
      @(posedge clk);
      #1;
      rstn = 1'b1; in_valid = '0; in_last = '0; use_src = 1'b1;
      log_id.delete(); log_cyc.delete(); log_last.delete(); log_data.delete();
   endtask

   task automatic expect_ids(input string name, input int exp[$]);
      check_output({name, "_count"}, 64'(log_id.size()), 64'(exp.size()));
      if (log_id.size() == exp.size())
         for (int k = 0; k < exp.size(); k++)
            check_output(name, 64'(log_id[k]), 64'(exp[k]));
   endtask

   initial begin
      // Grant-order vectors from ptr=0, single-beat packets, no backpressure.
      vecs[0] = '{1'b1, 4'b1111, 4'b0001};
      vecs[1] = '{1'b1, 4'b1111, 4'b0010};
      vecs[2] = '{1'b1, 4'b0011, 4'b0001};
      vecs[3] = '{1'b1, 4'b0110, 4'b0010};
      vecs[4] = '{1'b1, 4'b0000, 4'b0000};
      vecs[5] = '{1'b0, 4'b1111, 4'b0000};
      vecs[6] = '{1'b1, 4'b1000, 4'b1000};
      vecs[7] = '{1'b1, 4'b1110, 4'b0010};
      vecs[8] = '{1'b1, 4'b1011, 4'b1000};
      vecs[9] = '{1'b1, 4'b1010, 4'b0010};

      @(posedge clk);
      #1;
      do_reset();

      use_src = 1'b0;
      for (int e = 0; e < 10; e++) begin
         in_valid = vecs[e].valid;
         in_last  = '1;
         arb_en   = vecs[e].en;
         for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {8'(8'hA0 + i), 24'(e)};
         @(negedge clk);
         monitor();
         check_output("vec_ready", 64'(in_ready), 64'(vecs[e].exp_ready));
         @(posedge clk);
         #1;
      end
      in_valid = '0;
      arb_en   = 1'b1;
      repeat (3) apply_stimulus();

      do_reset();
      for (int i = 0; i < N; i++) begin
         pkt_q[i].push_back(1);
         pkt_q[i].push_back(1);
      end
      drive_sources();
      repeat (14) apply_stimulus();
      exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
      expect_ids("fair_id", exp_q);
      if (log_cyc.size() == 8)
         for (int k = 1; k < 8; k++) check_output("fair_rate", 64'(log_cyc[k] - log_cyc[0]), 64'(k));

      do_reset();
      pkt_q[0].push_back(4);
      drive_sources();
      apply_stimulus();
      pkt_q[1].push_back(1);
      drive_sources();
      repeat (10) apply_stimulus();
      exp_q = '{0, 0, 0, 0, 1};
      expect_ids("lock_id", exp_q);
      if (log_last.size() == 5) begin
         check_output("lock_last3", 64'(log_last[3]), 64'(1));
         check_output("lock_last2", 64'(log_last[2]), 64'(0));
      end

      do_reset();
      pkt_q[2].push_back(8);
      drive_sources();
      for (int c = 0; c < 30; c++) begin
         out_ready = ~out_ready;
         apply_stimulus();
      end
      out_ready = 1'b1;
      repeat (3) apply_stimulus();
      check_output("bp_count", 64'(log_data.size()), 64'(8));
      if (log_data.size() == 8) begin
         for (int k = 0; k < 8; k++) check_output("bp_data", 64'(log_data[k]), 64'({8'd2, 24'(k)}));
         check_output("bp_last", 64'(log_last[7]), 64'(1));
      end

      do_reset();
      pkt_q[2].push_back(1);
      drive_sources();
      repeat (3) apply_stimulus();
      pkt_q[3].push_back(1); pkt_q[3].push_back(1);
      pkt_q[0].push_back(1); pkt_q[0].push_back(1);
      drive_sources();
      repeat (10) apply_stimulus();
      exp_q = '{2, 3, 0, 3, 0};
      expect_ids("wrap_id", exp_q);

      do_reset();
      pkt_q[2].push_back(3);
      drive_sources();
      apply_stimulus();
      arb_en = 1'b0;
      pkt_q[1].push_back(4);
      drive_sources();
      for (int w = 0; w < 20 && !quiesced; w++) apply_stimulus();
      check_output("quiesce_reached", 64'(quiesced), 64'(1));
      check_output("quiesce_no_grant", 64'(in_ready), 64'(0));
      exp_q = '{2, 2, 2};
      expect_ids("quiesce_id", exp_q);
      arb_en = 1'b1;
      apply_stimulus();
      check_output("quiesce_drop", 64'(quiesced), 64'(0));
      apply_stimulus();
      do_reset();
      repeat (5) apply_stimulus();
      check_output("reset_no_tail", 64'(log_id.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
